// File: rtl/snn_pkg.sv
// Shared constants and types for the spiking-neuron tile monitors.
package snn_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned WIN_W_DEF = 16;
  localparam int unsigned ISI_W_DEF = 16;
  localparam int unsigned MIN_WIN   = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } mon_state_e;

endpackage

// File: rtl/sat_up_counter.sv
// Up counter that sticks at all-ones; load wins over increment, clear wins over both.
module sat_up_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  output logic [W-1:0] o_value,
  output logic         o_sat
);

  logic [W-1:0] r_value;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_inc && !o_sat) begin
      r_value <= r_value + 1'b1;
    end
  end

  assign o_value = r_value;
  assign o_sat   = (r_value == '1);

endmodule

// File: rtl/spike_rate_monitor.sv
// Spike-rate (spikes per programmable window) and inter-spike-interval monitor
// for a single neuron's spike output; all results registered with valid strobes.
module spike_rate_monitor
  import snn_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned WIN_W = WIN_W_DEF,
  parameter int unsigned ISI_W = ISI_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike,
  input  logic [WIN_W-1:0] win_len,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid,
  output logic             rate_sat
);

  mon_state_e       r_state;
  mon_state_e       w_state_nxt;
  logic             w_active;

  logic [WIN_W-1:0] r_rem;
  logic [WIN_W-1:0] w_win_n;
  logic             w_start;
  logic             w_last;

  logic [CNT_W-1:0] w_acc;
  logic             w_acc_sat;
  logic [CNT_W-1:0] w_acc_fin;
  logic             r_ovf;
  logic             w_ovf_fin;

  logic [ISI_W-1:0] w_gap;
  logic             w_gap_sat;
  logic             r_have_prev;

  logic [CNT_W-1:0] r_rate;
  logic             r_rate_valid;
  logic             r_rate_sat;
  logic [ISI_W-1:0] r_isi;
  logic             r_isi_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (en)  w_state_nxt = COUNT;
      COUNT:   if (!en) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_active = (r_state == COUNT) && en;
  end

  // r_rem == 0 in COUNT marks a window start; it holds the cycles left after this one.
  always_comb begin
    w_win_n = (win_len < WIN_W'(MIN_WIN)) ? WIN_W'(MIN_WIN) : win_len;
    w_start = w_active && (r_rem == '0);
    w_last  = w_active && (w_start ? (w_win_n == WIN_W'(1)) : (r_rem == WIN_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst || !w_active) begin
      r_rem <= '0;
    end else if (w_start) begin
      r_rem <= w_win_n - WIN_W'(1);
    end else begin
      r_rem <= r_rem - WIN_W'(1);
    end
  end

  sat_up_counter #(.W(CNT_W)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (!w_active),
    .i_load     (w_start),
    .i_load_val (CNT_W'(spike)),
    .i_inc      (w_active && !w_start && spike),
    .o_value    (w_acc),
    .o_sat      (w_acc_sat)
  );

  // Final window count includes this cycle's spike, which the counter has not absorbed yet.
  always_comb begin
    w_acc_fin = w_start ? CNT_W'(spike) : (w_acc + CNT_W'(spike && !w_acc_sat));
    w_ovf_fin = !w_start && (r_ovf || (spike && w_acc_sat));
  end

  always_ff @(posedge clk) begin
    if (rst || !w_active) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_fin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rate       <= '0;
      r_rate_sat   <= 1'b0;
      r_rate_valid <= 1'b0;
    end else begin
      r_rate_valid <= w_last;
      if (w_last) begin
        r_rate     <= w_acc_fin;
        r_rate_sat <= w_ovf_fin;
      end
    end
  end

  sat_up_counter #(.W(ISI_W)) u_gap (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (1'b0),
    .i_load     (w_active && spike),
    .i_load_val (ISI_W'(1)),
    .i_inc      (w_active && !spike && !w_gap_sat),
    .o_value    (w_gap),
    .o_sat      (w_gap_sat)
  );

  always_ff @(posedge clk) begin
    if (rst || (r_state == IDLE)) begin
      r_have_prev <= 1'b0;
    end else if (w_active && spike) begin
      r_have_prev <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_isi       <= '0;
      r_isi_valid <= 1'b0;
    end else begin
      r_isi_valid <= w_active && spike && r_have_prev;
      if (w_active && spike && r_have_prev) begin
        r_isi <= w_gap;
      end
    end
  end

  assign rate       = r_rate;
  assign rate_valid = r_rate_valid;
  assign rate_sat   = r_rate_sat;
  assign isi        = r_isi;
  assign isi_valid  = r_isi_valid;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed self-checking bench: a default-width instance and a narrow
// (CNT_W=2, ISI_W=4) instance driven by the same stimulus.
module tb_spike_rate_monitor;

  logic        clk;
  logic        rst;
  logic        en;
  logic        spike;
  logic [15:0] win_len;

  logic [7:0]  rate;
  logic        rate_valid;
  logic [15:0] isi;
  logic        isi_valid;
  logic        rate_sat;

  logic [1:0]  rate_s;
  logic        rate_valid_s;
  logic [3:0]  isi_s;
  logic        isi_valid_s;
  logic        rate_sat_s;

  int checks;
  int failures;

  spike_rate_monitor #(.CNT_W(8), .WIN_W(16), .ISI_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .spike      (spike),
    .win_len    (win_len),
    .rate       (rate),
    .rate_valid (rate_valid),
    .isi        (isi),
    .isi_valid  (isi_valid),
    .rate_sat   (rate_sat)
  );

  spike_rate_monitor #(.CNT_W(2), .WIN_W(16), .ISI_W(4)) dut_s (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .spike      (spike),
    .win_len    (win_len),
    .rate       (rate_s),
    .rate_valid (rate_valid_s),
    .isi        (isi_s),
    .isi_valid  (isi_valid_s),
    .rate_sat   (rate_sat_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; spike = 1'b0; win_len = 16'd1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; spike = 1'b1; win_len = 16'd5;
    tick(); tick();
    checks++;
    if ({rate, rate_valid, isi, isi_valid, rate_sat} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rate=%0d rv=%b isi=%0d iv=%b sat=%b exp all 0",
               rate, rate_valid, isi, isi_valid, rate_sat);
    end
    checks++;
    if ({rate_s, rate_valid_s, isi_s, isi_valid_s, rate_sat_s} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_s got rate=%0d rv=%b isi=%0d iv=%b sat=%b exp all 0",
               rate_s, rate_valid_s, isi_s, isi_valid_s, rate_sat_s);
    end
    rst = 1'b0;
  endtask

  // Window of 10 with spikes on cycles 1, 4, 10, then a silent back-to-back window.
  task automatic test_window();
    do_reset();
    win_len = 16'd10; en = 1'b1; spike = 1'b0;
    tick();
    for (int c = 1; c <= 20; c++) begin
      spike = (c == 1) || (c == 4) || (c == 10);
      tick();
      checks++;
      if (rate_valid !== ((c == 10) || (c == 20))) begin
        failures++;
        $display("FAIL win_rate_valid c=%0d got=%b exp=%b", c, rate_valid, (c == 10) || (c == 20));
      end
      if (c == 10) begin
        checks++;
        if (rate !== 8'd3 || rate_sat !== 1'b0) begin
          failures++;
          $display("FAIL win_rate got=%0d sat=%b exp=3 sat=0", rate, rate_sat);
        end
      end
      if (c == 20) begin
        checks++;
        if (rate !== 8'd0) begin
          failures++;
          $display("FAIL win2_rate got=%0d exp=0", rate);
        end
      end
      if (c == 1) begin
        checks++;
        if (isi_valid !== 1'b0) begin
          failures++;
          $display("FAIL win_first_isi_valid got=%b exp=0", isi_valid);
        end
      end
      if (c == 4 || c == 10) begin
        checks++;
        if (isi_valid !== 1'b1 || isi !== ((c == 4) ? 16'd3 : 16'd6)) begin
          failures++;
          $display("FAIL win_isi c=%0d got=%0d v=%b exp=%0d v=1", c, isi, isi_valid,
                   (c == 4) ? 3 : 6);
        end
      end
    end
  endtask

  // Continuous spikes into a 2-bit count: windows of 4 saturate, a window of 3 just fits.
  task automatic test_saturation();
    do_reset();
    win_len = 16'd4; en = 1'b1; spike = 1'b1;
    tick();
    for (int c = 1; c <= 11; c++) begin
      win_len = (c >= 9) ? 16'd3 : 16'd4;
      spike = 1'b1;
      tick();
      checks++;
      if (rate_valid_s !== ((c == 4) || (c == 8) || (c == 11))) begin
        failures++;
        $display("FAIL sat_rate_valid c=%0d got=%b exp=%b", c, rate_valid_s,
                 (c == 4) || (c == 8) || (c == 11));
      end
      if (c == 4 || c == 8 || c == 11) begin
        checks++;
        if (rate_s !== 2'd3 || rate_sat_s !== (c <= 8)) begin
          failures++;
          $display("FAIL sat_rate c=%0d got=%0d sat=%b exp=3 sat=%b", c, rate_s, rate_sat_s, c <= 8);
        end
      end
      if (c == 4) begin
        checks++;
        if (rate !== 8'd4 || rate_sat !== 1'b0) begin
          failures++;
          $display("FAIL wide_rate got=%0d sat=%b exp=4 sat=0", rate, rate_sat);
        end
      end
    end
  endtask

  // Spikes on cycles 5, 8, 9: first gives nothing, then 3, then 1.
  task automatic test_isi();
    do_reset();
    win_len = 16'd100; en = 1'b1; spike = 1'b0;
    tick();
    for (int c = 1; c <= 10; c++) begin
      spike = (c == 5) || (c == 8) || (c == 9);
      tick();
      checks++;
      if (isi_valid !== ((c == 8) || (c == 9))) begin
        failures++;
        $display("FAIL isi_valid c=%0d got=%b exp=%b", c, isi_valid, (c == 8) || (c == 9));
      end
      if (c == 8 || c == 9) begin
        checks++;
        if (isi !== ((c == 8) ? 16'd3 : 16'd1)) begin
          failures++;
          $display("FAIL isi_value c=%0d got=%0d exp=%0d", c, isi, (c == 8) ? 3 : 1);
        end
      end
    end
  endtask

  // en drops mid-window: partial count discarded, old rate held, fresh window on re-enable.
  task automatic test_en_drop();
    do_reset();
    win_len = 16'd2; en = 1'b1; spike = 1'b0;
    tick();
    spike = 1'b1; tick(); tick();
    checks++;
    if (rate_valid !== 1'b1 || rate !== 8'd2) begin
      failures++;
      $display("FAIL drop_pre_rate got=%0d v=%b exp=2 v=1", rate, rate_valid);
    end
    win_len = 16'd8;
    for (int w = 1; w <= 4; w++) begin
      spike = (w == 1) || (w == 3);
      tick();
      checks++;
      if (rate_valid !== 1'b0) begin
        failures++;
        $display("FAIL drop_partial_valid w=%0d got=%b exp=0", w, rate_valid);
      end
    end
    en = 1'b0; spike = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (rate_valid !== 1'b0 || isi_valid !== 1'b0) begin
        failures++;
        $display("FAIL drop_idle_valid k=%0d got rv=%b iv=%b exp 0 0", k, rate_valid, isi_valid);
      end
    end
    checks++;
    if (rate !== 8'd2 || rate_sat !== 1'b0) begin
      failures++;
      $display("FAIL drop_rate_hold got=%0d sat=%b exp=2 sat=0", rate, rate_sat);
    end
    en = 1'b1; win_len = 16'd4; spike = 1'b0;
    tick();
    for (int w = 1; w <= 4; w++) begin
      spike = (w == 2);
      tick();
      if (w == 2) begin
        checks++;
        if (isi_valid !== 1'b0) begin
          failures++;
          $display("FAIL drop_first_isi got=%b exp=0", isi_valid);
        end
      end
    end
    checks++;
    if (rate_valid !== 1'b1 || rate !== 8'd1) begin
      failures++;
      $display("FAIL drop_fresh_rate got=%0d v=%b exp=1 v=1", rate, rate_valid);
    end
  endtask

  // win_len=0 behaves as 1: a rate every cycle equal to that cycle's spike.
  task automatic test_zero_len();
    do_reset();
    win_len = 16'd0; en = 1'b1; spike = 1'b0;
    tick();
    for (int c = 1; c <= 6; c++) begin
      logic s;
      s = (c % 2) == 1;
      spike = s;
      tick();
      checks++;
      if (rate_valid !== 1'b1 || rate !== {7'd0, s}) begin
        failures++;
        $display("FAIL zero_len c=%0d got=%0d v=%b exp=%0d v=1", c, rate, rate_valid, s);
      end
    end
  endtask

  // 20 silent cycles between spikes: gap of 21, which a 4-bit ISI clamps to 15.
  task automatic test_isi_sat();
    do_reset();
    win_len = 16'd100; en = 1'b1; spike = 1'b0;
    tick();
    spike = 1'b1; tick();
    spike = 1'b0;
    repeat (20) tick();
    spike = 1'b1; tick();
    checks++;
    if (isi_valid_s !== 1'b1 || isi_s !== 4'd15) begin
      failures++;
      $display("FAIL isi_sat got=%0d v=%b exp=15 v=1", isi_s, isi_valid_s);
    end
    checks++;
    if (isi_valid !== 1'b1 || isi !== 16'd21) begin
      failures++;
      $display("FAIL isi_wide got=%0d v=%b exp=21 v=1", isi, isi_valid);
    end
  endtask

  // Reset on a cycle that would otherwise pulse both valids.
  task automatic test_reset_mid();
    do_reset();
    win_len = 16'd2; en = 1'b1; spike = 1'b0;
    tick();
    spike = 1'b1; tick(); tick();
    checks++;
    if (rate !== 8'd2 || rate_valid !== 1'b1 || isi_valid !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pre got rate=%0d rv=%b iv=%b exp 2 1 1", rate, rate_valid, isi_valid);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({rate, rate_valid, isi, isi_valid, rate_sat} !== '0) begin
      failures++;
      $display("FAIL rmid_outputs got rate=%0d rv=%b isi=%0d iv=%b sat=%b exp all 0",
               rate, rate_valid, isi, isi_valid, rate_sat);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({rate, rate_valid, isi, isi_valid, rate_sat} !== '0) begin
      failures++;
      $display("FAIL rmid_after got rate=%0d rv=%b isi=%0d iv=%b sat=%b exp all 0",
               rate, rate_valid, isi, isi_valid, rate_sat);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; en = 1'b0; spike = 1'b0; win_len = 16'd1;
    test_reset();
    test_window();
    test_saturation();
    test_isi();
    test_en_drop();
    test_zero_len();
    test_isi_sat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
